wave_dispatcher: RTL
====================

Name: wave_dispatcher

Overview:
- Per-compute-unit scheduler between the block dispatcher and NUM_SIMDS SIMD units.
- Accepts one thread block, splits it into ceil(block_dim / WAVE_SIZE) waves, and assigns each wave to an idle SIMD using the simd_ready/start/working/done handshake.
- Counts wave completions and reports block completion upstream.
- Owns all per-SIMD wave_id, block_id and num_waves_in_block values.

Parameters:
- NUM_SIMDS, 2, number of SIMD units served.
- WAVE_SIZE, 32, threads per wave.
- MAX_WAVES, 8, maximum waves per block; sets counter widths ($clog2(MAX_WAVES)+1).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  global enable; low freezes all state
- block_start  input  1  one-cycle pulse: new block valid
- block_id  input  32  signed block index, latched on accept
- block_dim  input  32  threads per block, latched on accept
- block_busy  output  1  high from accept until block_done
- block_done  output  1  one-cycle pulse: all waves finished
- block_err  output  1  one-cycle pulse: block rejected (block_dim > MAX_WAVES*WAVE_SIZE)
- simd_done  input  NUM_SIMDS  per-SIMD done, level, held by the SIMD until its next simd_start
- simd_ready  output  NUM_SIMDS  per-SIMD slot idle
- simd_start  output  NUM_SIMDS  per-SIMD one-cycle dispatch pulse
- simd_working  output  NUM_SIMDS  per-SIMD wave in flight
- simd_wave_id  output  NUM_SIMDS*32  flattened signed wave_id per SIMD; slot s occupies [32s+31:32s]
- simd_block_id  output  32  latched block_id, common to all SIMDs
- num_waves_in_block  output  32  latched wave count

Behaviour:
- Reset, asynchronous: top FSM=IDLE, all slots=S_IDLE.
  - simd_ready all 1; simd_start, simd_working, block_busy, block_done, block_err all 0.
  - All wave_ids, simd_block_id, num_waves_in_block and counters are 0.
- Reset mid-block: aborts immediately and drops all in-flight bookkeeping; no block_done is issued.
- enable=0: no state changes, no pulses, no counting. Outputs hold, except single-cycle pulses, which deassert.
- Top FSM states are IDLE, DISPATCH, DRAIN, DONE.
  - IDLE + block_start: latch block_id and block_dim; compute nw = (block_dim + WAVE_SIZE - 1) / WAVE_SIZE in 32-bit unsigned arithmetic.
    - nw == 0: go to DONE.
    - nw > MAX_WAVES: pulse block_err next cycle and stay IDLE.
    - Otherwise: num_waves_in_block = nw, next_wave = 0, waves_done = 0, block_busy = 1, go to DISPATCH.
  - block_start outside IDLE is ignored. No queuing.
  - DISPATCH: each cycle, if next_wave < nw and any slot is S_IDLE, pick the lowest-indexed idle slot s.
    - Set simd_wave_id[s] = next_wave, pulse simd_start[s] for one cycle, increment next_wave.
    - At most one dispatch per cycle.
    - When next_wave reaches nw, go to DRAIN.
  - DRAIN: wait until waves_done == nw, then go to DONE.
  - DONE: block_done=1 for exactly one cycle; block_busy drops in the same cycle; next state IDLE.
  - DISPATCH and DRAIN both check for completion. Completion requires waves_done == nw and next_wave == nw.
- Per-slot FSM, S_IDLE -> S_START -> S_WORK -> S_IDLE:
  - S_IDLE: ready=1.
  - S_START: lasts one cycle; start=1, ready=0.
  - S_WORK: working=1; stays until simd_done[s]=1.
  - On exit from S_WORK, the slot increments waves_done in the same clock edge.
  - simd_done[s] is ignored unless the slot is in S_WORK.
- Simultaneous events:
  - Several slots finishing in one cycle add their popcount to waves_done.
  - A slot that finishes in cycle t is dispatchable at t+1, not at t.
  - Dispatch and completion in the same cycle are both honoured.
- Latency:
  - block_start to first simd_start: 2 cycles (accept edge, then dispatch edge).
  - Last simd_done to block_done: 2 cycles.
- Widths: counters are $clog2(MAX_WAVES)+1 bits; wave_id is zero-extended to 32 bits.

Decomposition:
- Shared package/common_defs: top FSM state encodings, slot state encodings, and the SIMD handshake constants shared with the SIMD controller.
- One natural sub-module: wave_slot. It holds the per-SIMD state machine, the wave_id register and the done-detect pulse, and is instantiated NUM_SIMDS times under generate.
- The top level holds the arbiter (lowest-index priority), the counters and the top FSM.

Test Plan:
- Reset in the middle of a 4-wave block (block_dim=128) after 2 starts → all outputs at reset values the same cycle; no block_done; a new block_start is accepted afterwards.
- block_dim=64, 2 SIMDs, each simd_done raised 5 cycles after its start → wave 0 to SIMD0 and wave 1 to SIMD1 on consecutive cycles; one block_done; num_waves_in_block=2.
- block_dim=100 → nw=4. Waves 0,1 go out first; waves 2,3 go out only after the respective simd_done; waves_done reaches 4; block_done 2 cycles after the last done.
- Both simd_done asserted in the same cycle with nw=2 → waves_done increments by 2; single block_done pulse.
- block_dim=0 → block_done one cycle after accept, no simd_start. block_dim=257 → block_err pulse, no dispatch, FSM stays IDLE.
- block_start pulsed while busy, plus enable held low for 3 cycles mid-DISPATCH → the extra block_start is ignored; no start pulses while enable is low; dispatch resumes exactly where it stopped.

Source files
------------

// File: rtl/wave_dispatcher_pkg.sv
// Shared types and constants for the wave dispatcher and its per-SIMD slots.
package wave_dispatcher_pkg;

  // Width of every id/count word exchanged with the block dispatcher and SIMD controllers.
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDrain,
    StDone
  } top_state_e;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotStart,
    SlotWork
  } slot_state_e;

  // Wraps modulo 2^32 like the upstream dispatcher does, so huge block_dim can alias to 0 waves.
  function automatic logic [DataW-1:0] calc_num_waves(input logic [DataW-1:0] dim,
                                                      input logic [DataW-1:0] wave_size);
    return (dim + wave_size - 32'd1) / wave_size;
  endfunction

endpackage

// File: rtl/wave_dispatcher_if.sv
// Block-side and SIMD-side handshake bundle of the wave dispatcher.
interface wave_dispatcher_if #(
  parameter int unsigned NUM_SIMDS = 2
);
  import wave_dispatcher_pkg::*;

  logic                        block_start;
  logic signed [DataW-1:0]     block_id;
  logic [DataW-1:0]            block_dim;
  logic                        block_busy;
  logic                        block_done;
  logic                        block_err;
  logic [NUM_SIMDS-1:0]        simd_done;
  logic [NUM_SIMDS-1:0]        simd_ready;
  logic [NUM_SIMDS-1:0]        simd_start;
  logic [NUM_SIMDS-1:0]        simd_working;
  logic [NUM_SIMDS*DataW-1:0]  simd_wave_id;
  logic signed [DataW-1:0]     simd_block_id;
  logic [DataW-1:0]            num_waves_in_block;

  modport master (
    input  block_start, block_id, block_dim, simd_done,
    output block_busy, block_done, block_err, simd_ready, simd_start, simd_working,
           simd_wave_id, simd_block_id, num_waves_in_block
  );

  modport slave (
    output block_start, block_id, block_dim, simd_done,
    input  block_busy, block_done, block_err, simd_ready, simd_start, simd_working,
           simd_wave_id, simd_block_id, num_waves_in_block
  );

endinterface

// File: rtl/wave_dispatcher_wave_slot.sv
// One SIMD slot: idle/start/work state machine, assigned wave_id and completion detect.
module wave_dispatcher_wave_slot
  import wave_dispatcher_pkg::*;
#(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_enable,
  input  logic            i_start,
  input  logic [CntW-1:0] i_wave_id,
  input  logic            i_simd_done,
  output logic            o_ready,
  output logic            o_start,
  output logic            o_working,
  output logic            o_done,
  output logic [CntW-1:0] o_wave_id
);

  slot_state_e     r_state;
  slot_state_e     w_state_next;
  logic [CntW-1:0] r_wave_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SlotIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wave_id <= '0;
    end else if (i_enable && i_start && (r_state == SlotIdle)) begin
      r_wave_id <= i_wave_id;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_enable) begin
      unique case (r_state)
        SlotIdle:  if (i_start) w_state_next = SlotStart;
        SlotStart: w_state_next = SlotWork;
        SlotWork:  if (i_simd_done) w_state_next = SlotIdle;
        default:   w_state_next = SlotIdle;
      endcase
    end
  end

  // Pulses are masked by enable so a frozen slot never repeats them.
  always_comb begin
    o_ready   = (r_state == SlotIdle);
    o_start   = i_enable && (r_state == SlotStart);
    o_working = (r_state == SlotWork);
    o_done    = i_enable && (r_state == SlotWork) && i_simd_done;
    o_wave_id = r_wave_id;
  end

endmodule

// File: rtl/wave_dispatcher.sv
// Per-CU scheduler: splits a thread block into waves and hands them to idle SIMD slots.
module wave_dispatcher
  import wave_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_SIMDS = 2,
  parameter int unsigned WAVE_SIZE = 32,
  parameter int unsigned MAX_WAVES = 8
) (
  input logic         clk,
  input logic         rst,
  input logic         enable,
  wave_dispatcher_if.master bus
);

  localparam int unsigned CntW = $clog2(MAX_WAVES) + 1;

  top_state_e              r_state;
  top_state_e              w_state_next;
  logic [CntW-1:0]         r_next_wave;
  logic [CntW-1:0]         r_waves_done;
  logic [CntW-1:0]         r_num_waves;
  logic signed [DataW-1:0] r_block_id;
  logic                    r_block_err;

  logic [DataW-1:0]        w_nw_full;
  logic                    w_accept;
  logic                    w_accept_zero;
  logic                    w_accept_err;
  logic                    w_accept_ok;
  logic                    w_dispatch;
  logic                    w_complete;
  logic [NUM_SIMDS-1:0]    w_idle;
  logic [NUM_SIMDS-1:0]    w_grant;
  logic [NUM_SIMDS-1:0]    w_start;
  logic [NUM_SIMDS-1:0]    w_working;
  logic [NUM_SIMDS-1:0]    w_done;
  logic [CntW-1:0]         w_done_cnt;
  logic [CntW-1:0]         w_wave_id [NUM_SIMDS];

  assign w_nw_full     = calc_num_waves(bus.block_dim, WAVE_SIZE);
  assign w_accept      = enable && (r_state == StIdle) && bus.block_start;
  assign w_accept_zero = w_accept && (w_nw_full == '0);
  assign w_accept_err  = w_accept && (w_nw_full > MAX_WAVES);
  assign w_accept_ok   = w_accept && !w_accept_zero && !w_accept_err;
  assign w_dispatch    = enable && (r_state == StDispatch) && (r_next_wave < r_num_waves) &&
                         (|w_idle);
  assign w_complete    = (r_waves_done == r_num_waves) && (r_next_wave == r_num_waves);

  // Lowest-indexed idle slot wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    w_grant = '0;
    for (int s = 0; s < int'(NUM_SIMDS); s++) begin
      if (w_idle[s] && !found) begin
        w_grant[s] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_done_cnt = '0;
    for (int s = 0; s < int'(NUM_SIMDS); s++) begin
      w_done_cnt = w_done_cnt + CntW'(w_done[s]);
    end
  end

  for (genvar s = 0; s < int'(NUM_SIMDS); s++) begin : g_slot
    wave_dispatcher_wave_slot #(
      .CntW (CntW)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_enable    (enable),
      .i_start     (w_dispatch && w_grant[s]),
      .i_wave_id   (r_next_wave),
      .i_simd_done (bus.simd_done[s]),
      .o_ready     (w_idle[s]),
      .o_start     (w_start[s]),
      .o_working   (w_working[s]),
      .o_done      (w_done[s]),
      .o_wave_id   (w_wave_id[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_next_wave  <= '0;
      r_waves_done <= '0;
      r_num_waves  <= '0;
      r_block_id   <= '0;
      r_block_err  <= 1'b0;
    end else if (enable) begin
      r_block_err <= w_accept_err;
      if (w_accept) begin
        r_block_id <= bus.block_id;
      end
      if (w_accept && !w_accept_err) begin
        r_num_waves  <= w_nw_full[CntW-1:0];
        r_next_wave  <= '0;
        r_waves_done <= '0;
      end else begin
        if (w_dispatch) begin
          r_next_wave <= r_next_wave + CntW'(1);
        end
        r_waves_done <= r_waves_done + w_done_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (enable) begin
      unique case (r_state)
        StIdle: begin
          if (w_accept_zero) begin
            w_state_next = StDone;
          end else if (w_accept_ok) begin
            w_state_next = StDispatch;
          end
        end
        StDispatch: begin
          if (w_complete) begin
            w_state_next = StDone;
          end else if (w_dispatch && ((r_next_wave + CntW'(1)) == r_num_waves)) begin
            w_state_next = StDrain;
          end
        end
        StDrain: if (w_complete) w_state_next = StDone;
        StDone:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.block_busy         = (r_state == StDispatch) || (r_state == StDrain);
    bus.block_done         = enable && (r_state == StDone);
    bus.block_err          = enable && r_block_err;
    bus.simd_block_id      = r_block_id;
    bus.num_waves_in_block = DataW'(r_num_waves);
    bus.simd_ready         = w_idle;
    bus.simd_start         = w_start;
    bus.simd_working       = w_working;
    bus.simd_wave_id       = '0;
    for (int s = 0; s < int'(NUM_SIMDS); s++) begin
      bus.simd_wave_id[DataW*s +: DataW] = DataW'(w_wave_id[s]);
    end
  end

endmodule
